// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle 32x32 multiply / 32/32 divide engine that feeds the
// HI/LO register pair. It iterates one bit per cycle, using shift-add for
// multiply and restoring division for divide. The result appears on Ans with
// a one-cycle done strobe.
//
// Optional feature: define SIGNED_MD_EN to make op[1] select signed
// two's-complement operation. When the macro is undefined, op[1] is ignored.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     operation request, sampled only in IDLE
//   op        op[0]: 0 = multiply, 1 = divide; op[1]: signed select
//   a, b      multiplicand/dividend, multiplier/divisor
//   busy      high while in RUN or DONE
//   done      one-cycle strobe, Ans valid in the same cycle
//   div_zero  high with done when a divide had b == 0
//   Ans       multiply: full product; divide: {remainder, quotient}
module mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero,
    output logic [2*WIDTH-1:0]   Ans
);

    localparam int unsigned AW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   opa_q;      // multiplicand, or dividend shifting out MSB-first
    logic [WIDTH-1:0]   opb_q;      // multiplier shifting out LSB-first, or divisor
    logic [AW-1:0]      acc_q;      // mul: {carry, hi, lo}; div: {0, rem, quo}
    logic               is_div_q;

    logic               accept_c;
    logic               dz_c;
    logic               last_c;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [WIDTH:0]     rem_sh_c;
    logic [WIDTH:0]     trial_c;
    logic [AW-1:0]      acc_step_c;
    logic [WIDTH-1:0]   quo_c;
    logic [WIDTH-1:0]   rem_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [2*WIDTH-1:0] res_c;

    assign accept_c = (state_q == IDLE) && start;
    assign dz_c     = op[0] && (b == '0);
    assign last_c   = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SIGNED_MD_EN
    logic a_neg_c, b_neg_c;
    logic neg_res_q;                // product/quotient sign
    logic neg_rem_q;                // remainder follows dividend sign

    assign a_neg_c = op[1] & a[WIDTH-1];
    assign b_neg_c = op[1] & b[WIDTH-1];
    assign a_mag_c = a_neg_c ? -a : a;
    assign b_mag_c = b_neg_c ? -b : b;

    // Sign bookkeeping captured at acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept_c) begin
            neg_res_q <= a_neg_c ^ b_neg_c;
            neg_rem_q <= a_neg_c;
        end
    end
`else
    logic unused_op_sign;

    assign a_mag_c        = a;
    assign b_mag_c        = b;
    assign unused_op_sign = op[1];
`endif

    // One shift-add or restoring-divide iteration
    always_comb begin
        mul_sum_c  = acc_q[AW-1:WIDTH] + {1'b0, (opb_q[0] ? opa_q : WIDTH'(0))};
        rem_sh_c   = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
        trial_c    = rem_sh_c - {1'b0, opb_q};
        acc_step_c = '0;
        if (is_div_q) begin
            if (!trial_c[WIDTH]) begin
                acc_step_c = {1'b0, trial_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_c = {1'b0, rem_sh_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step_c = {mul_sum_c, acc_q[WIDTH-1:0]} >> 1;
        end
    end

    // Final result, sign-corrected when signed operation is enabled
    always_comb begin
        quo_c  = acc_step_c[WIDTH-1:0];
        rem_c  = acc_step_c[2*WIDTH-1:WIDTH];
        prod_c = acc_step_c[2*WIDTH-1:0];
`ifdef SIGNED_MD_EN
        if (neg_res_q) begin
            quo_c  = -acc_step_c[WIDTH-1:0];
            prod_c = -acc_step_c[2*WIDTH-1:0];
        end
        if (neg_rem_q) begin
            rem_c = -acc_step_c[2*WIDTH-1:WIDTH];
        end
`endif
        res_c = is_div_q ? {rem_c, quo_c} : prod_c;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = dz_c ? DONE : RUN;
            RUN:     if (last_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            is_div_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            Ans      <= '0;
        end else begin
            busy     <= (state_d != IDLE);
            done     <= (state_d == DONE);
            div_zero <= accept_c && dz_c;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opa_q    <= a_mag_c;
                        opb_q    <= b_mag_c;
                        is_div_q <= op[0];
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        if (dz_c) begin
                            Ans <= {a, {WIDTH{1'b1}}};
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_step_c;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        opa_q <= opa_q << 1;
                    end else begin
                        opb_q <= opb_q >> 1;
                    end
                    if (last_c) begin
                        Ans <= res_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit. It applies a table of directed vectors and
// hand-written corner sequences (start while busy, reset mid-operation), then
// runs random operations checked against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [63:0] Ans;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .Ans      (Ans)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [1:0]  vop;
        logic [63:0] ans;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model in plain arithmetic
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] o);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q = 0;
        r = 0;
        if (!o[0]) begin
`ifdef SIGNED_MD_EN
            if (o[1]) return 64'(sx * sy);
`endif
            return 64'(x) * 64'(y);
        end
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
`ifdef SIGNED_MD_EN
        if (o[1]) begin
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
        end
`endif
        return {x % y, x / y};
    endfunction

    // Issue one operation from IDLE and check its whole lifetime
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic [1:0] top,
                          input logic [63:0] exp_ans, input logic exp_dz, input string tag);
        int cyc;
        int busy_cyc;
        int exp_lat;
        logic [63:0] held;
        exp_lat = exp_dz ? 1 : 33;
        @(negedge clk);
        start = 1'b1;
        a = ta;
        b = tbv;
        op = top;
        @(posedge clk);
        cyc = 0;
        busy_cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            a = $urandom;
            b = $urandom;
            op = 2'($urandom);
            cyc++;
            if (busy) busy_cyc++;
        end while (!done && cyc < 80);
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " ans"}, Ans, exp_ans);
        check({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
        check({tag, " busy cycles"}, 64'(busy_cyc), 64'(exp_lat));
        held = Ans;
        @(negedge clk);
        check({tag, " done falls"}, 64'(done), 64'd0);
        check({tag, " busy falls"}, 64'(busy), 64'd0);
        check({tag, " ans holds"}, Ans, held);
    endtask

    vec_t vecs[$];

    initial begin
        int cyc;
        int ndone;
        logic [31:0] ra, rb;
        logic [1:0]  rop;

        reset = 1'b0;
        start = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;

        // Reset state
        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        check("reset ans", Ans, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vector table
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 64'hFFFF_FFFE_0000_0001, 1'b0});
        vecs.push_back('{32'd100, 32'd7, 2'b01, 64'h0000_0002_0000_000E, 1'b0});
        vecs.push_back('{32'h1234_5678, 32'd0, 2'b01, 64'h1234_5678_FFFF_FFFF, 1'b1});
        vecs.push_back('{32'd0, 32'hDEAD_BEEF, 2'b00, 64'd0, 1'b0});
        vecs.push_back('{32'd5, 32'd10, 2'b01, 64'h0000_0005_0000_0000, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'd1, 2'b01, 64'h0000_0000_FFFF_FFFF, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'd0, 2'b11, 64'h8000_0000_FFFF_FFFF, 1'b1});
`ifdef SIGNED_MD_EN
        vecs.push_back('{32'hFFFF_FFF9, 32'd2, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
        vecs.push_back('{32'hFFFF_FFFD, 32'd5, 2'b10, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 64'h0000_0000_8000_0000, 1'b0});
`else
        vecs.push_back('{32'hFFFF_FFF9, 32'd2, 2'b11, 64'h0000_0001_7FFF_FFFC, 1'b0});
        vecs.push_back('{32'hFFFF_FFFD, 32'd5, 2'b10, 64'h0000_0004_FFFF_FFF1, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 64'h8000_0000_0000_0000, 1'b0});
`endif
        foreach (vecs[i]) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vop, vecs[i].ans, vecs[i].dz,
                   $sformatf("vec%0d", i));
        end

        // Start while busy: held start is ignored until IDLE, then launches one op
        @(negedge clk);
        start = 1'b1;
        a = 32'd6;
        b = 32'd7;
        op = 2'b00;
        @(posedge clk);
        cyc = 0;
        ndone = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (cyc == 10) begin
                start = 1'b1;
                a = 32'd3;
                b = 32'd3;
            end
        end while (!done && cyc < 80);
        check("busy-start latency", 64'(cyc), 64'd33);
        check("busy-start first ans", Ans, 64'd42);
        @(negedge clk);
        check("busy-start idle gap", 64'(busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("held start accepted", 64'(busy), 64'd1);
        cyc = 1;
        while (!done && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        check("held start latency", 64'(cyc), 64'd33);
        check("held start ans", Ans, 64'd9);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("held start single op", 64'(ndone), 64'd0);

        // Reset mid-divide clears outputs asynchronously
        @(negedge clk);
        start = 1'b1;
        a = 32'd1000;
        b = 32'd3;
        op = 2'b01;
        @(posedge clk);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        reset = 1'b0;
        #1;
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset done", 64'(done), 64'd0);
        check("async reset ans", Ans, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("no done after reset", 64'(ndone), 64'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rop = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
            run_op(ra, rb, rop, model(ra, rb, rop), rop[0] && (rb == 32'd0),
                   $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
